cp0_reg: RTL
============

# cp0_reg

Coprocessor-0 register file for the five-stage MIPS32 pipeline. It answers the EX stage's CP0 read port (`cp0_rd_addr_o` → `cp0_data_i`) and accepts committed `mtc0` writes from MEM/WB. It records exception state from the MEM-stage exception arbiter and runs the Count/Compare timer. It also produces the pending-interrupt flag consumed by the exception logic.

## Interface
Parameters:
- `PRID_VALUE`, default 32'h0001_8000: read-only PRId (reg 15) contents.
- `STATUS_RESET`, default 32'h1000_0000: Status value after reset (CU0=1, IE=0, EXL=0).

Ports:
- `clk` in 1: pipeline clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `raddr_i` in 5: read address from EX (`cp0_rd_addr_o`).
- `data_o` out 32: read data to EX (`cp0_data_i`); combinational.
- `we_i` in 1: committed mtc0 write enable (MEM/WB `wb_cp0_we`).
- `waddr_i` in 5: write address.
- `wdata_i` in 32: write data.
- `int_i` in 6: external hardware interrupts, level-sensitive, already synchronous to `clk`.
- `exc_valid_i` in 1: exception taken this cycle.
- `exc_code_i` in 5: ExcCode for Cause[6:2].
- `exc_pc_i` in 32: PC of the faulting instruction.
- `exc_bd_i` in 1: faulting instruction is in a delay slot.
- `exc_badvaddr_i` in 32: faulting address; used for AdEL/AdES only.
- `eret_i` in 1: eret committed this cycle.
- `status_o`, `cause_o`, `epc_o` out 32: live register values for the exception arbiter and the eret target.
- `int_pending_o` out 1: Status.IE & ~Status.EXL & |(Cause.IP & Status.IM).
- `timer_int_o` out 1: Count/Compare match, sticky.

## Operation
- Registers: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14), PRId(15). Any other address reads 0, and writes to it are ignored.
- Reset values: BadVAddr, Count, Compare, Cause, EPC = 0. Status = `STATUS_RESET`. `timer_int_o` = 0. `data_o` therefore follows `raddr_i` over the reset values.
- Write masks:
  - Status: only IM[15:8], EXL[1] and IE[0] are writable.
  - Cause: only IP[9:8] (software interrupts) is writable.
  - Count, Compare, EPC: fully writable.
  - BadVAddr, PRId: read-only.
- Cause.IP[15:10] is loaded from {`timer_int_o` | `int_i`[5], `int_i`[4:0]} every cycle. It cannot be written by software.
- Count increments by 1 every cycle and wraps from 32'hFFFF_FFFF to 0. A write to Count loads `wdata_i` and suppresses that cycle's increment.
- A write to Compare clears `timer_int_o`.
- `timer_int_o` sets when Count equals Compare and stays set until a Compare write. Set and clear in the same cycle resolves to clear.
- On exception (`exc_valid_i`):
  - If Status.EXL=0: EPC <= `exc_bd_i` ? `exc_pc_i`-4 : `exc_pc_i`; Cause.BD <= `exc_bd_i`; Status.EXL <= 1.
  - If Status.EXL=1: EPC, BD and EXL are unchanged.
  - Cause.ExcCode <= `exc_code_i` in both cases.
  - BadVAddr <= `exc_badvaddr_i` when the code is AdEL (4) or AdES (5).
- On `eret_i`: Status.EXL <= 0.
- Priority: `exc_valid_i` > `eret_i` > `we_i`. The lower-priority actions are dropped entirely in that cycle. Count increment and Cause.IP sampling still occur.
- No internal bypass: the read port returns pre-edge register contents. EX forwards from MEM and MEM/WB itself.

## Timing
- Read: zero latency, combinational from `raddr_i` and the register state.
- Write: visible on `data_o` the cycle after `we_i`.
- Exception/eret: EPC, Status and Cause are updated at the edge ending the cycle; `status_o`, `cause_o` and `epc_o` show the new values in the following cycle.
- Timer: if Count reaches Compare after edge N, `timer_int_o` is high after edge N+1, and Cause.IP7 reflects it after edge N+2.
- `int_pending_o`: combinational from the registered Status and Cause.
- Reset mid-operation: all state returns to reset values immediately, with no edge needed. The first Count increment occurs on the first edge with `rst` high.

## Configuration
- `CP0_TIMER_EN` defined: Count, Compare and `timer_int_o` behave as above.
- Not defined:
  - Count and Compare read 0, and writes to them are ignored.
  - `timer_int_o` is tied to 0.
  - Cause.IP7 reflects `int_i`[5] only.

## Structure
- Shared header `defines.vh` holds:
  - CP0 register address constants (`CP0_REG_COUNT` etc.).
  - ExcCode constants.
  - Status and Cause write masks.
  - Existing `DataBus` and `RegAddrBus` widths.
- One sub-module, `cp0_timer`: Count counter, Compare register and sticky match flag. It is instantiated only under `CP0_TIMER_EN`.

## Test plan
- Reset, then write Status=32'hFFFF_FFFF → read 32'h1000_FF03. Write Cause=32'hFFFF_FFFF with `int_i`=0 → read 32'h0000_0300.
- Write Compare=10, then write Count=5 → `timer_int_o` rises 6 cycles after the Count write. Write Compare=20 → `timer_int_o` falls the next cycle.
- Exception with code 4, pc 32'hBFC0_0100, bd=1, badvaddr 32'h1 → EPC=32'hBFC0_00FC, Cause.BD=1, ExcCode=4, BadVAddr=1, EXL=1. A second exception with code 8 → EPC unchanged, ExcCode=8.
- `exc_valid_i` and `we_i` to EPC asserted in the same cycle → EPC holds the exception value and the write is lost. `eret_i` asserted → EXL=0 next cycle.
- Status IE=1, IM[10]=1, `int_i`=6'b000001 → `int_pending_o`=1 one cycle after `int_i` rises. Set EXL → 0.
- Write Count=32'hFFFF_FFFF → reads 0 on the next cycle. Pulse `rst` low mid-count → Count=0 immediately.

Source files
------------

// File: rtl/cp0_reg_pkg.sv
// Shared CP0 constants: bus widths, register addresses, ExcCodes and software write masks.
package cp0_reg_pkg;

   localparam int DATA_BUS_W     = 32;
   localparam int REG_ADDR_BUS_W = 5;

   typedef logic [DATA_BUS_W-1:0]     data_bus_t;
   typedef logic [REG_ADDR_BUS_W-1:0] reg_addr_t;

   localparam reg_addr_t CP0_REG_BADVADDR = 5'd8;
   localparam reg_addr_t CP0_REG_COUNT    = 5'd9;
   localparam reg_addr_t CP0_REG_COMPARE  = 5'd11;
   localparam reg_addr_t CP0_REG_STATUS   = 5'd12;
   localparam reg_addr_t CP0_REG_CAUSE    = 5'd13;
   localparam reg_addr_t CP0_REG_EPC      = 5'd14;
   localparam reg_addr_t CP0_REG_PRID     = 5'd15;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_SYS  = 5'd8;
   localparam logic [4:0] EXC_BP   = 5'd9;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   // IM[15:8], EXL, IE in Status; software interrupt bits IP[9:8] in Cause
   localparam data_bus_t STATUS_WMASK = 32'h0000_FF03;
   localparam data_bus_t CAUSE_WMASK  = 32'h0000_0300;

   localparam int STATUS_IE_BIT  = 0;
   localparam int STATUS_EXL_BIT = 1;
   localparam int CAUSE_BD_BIT   = 31;

   function automatic data_bus_t masked_write(data_bus_t old_val, data_bus_t new_val,
                                              data_bus_t mask);
      return (old_val & ~mask) | (new_val & mask);
   endfunction

endpackage

// File: rtl/cp0_if.sv
// CP0 port bundle between the pipeline (master) and the CP0 register file (slave).
// No handshake: reads are combinational, writes/exceptions/eret are single-cycle strobes.
interface cp0_if;
   import cp0_reg_pkg::*;

   reg_addr_t  raddr_i;
   data_bus_t  data_o;
   logic       we_i;
   reg_addr_t  waddr_i;
   data_bus_t  wdata_i;
   logic [5:0] int_i;
   logic       exc_valid_i;
   logic [4:0] exc_code_i;
   data_bus_t  exc_pc_i;
   logic       exc_bd_i;
   data_bus_t  exc_badvaddr_i;
   logic       eret_i;
   data_bus_t  status_o;
   data_bus_t  cause_o;
   data_bus_t  epc_o;
   logic       int_pending_o;
   logic       timer_int_o;

   modport master (
      output raddr_i, we_i, waddr_i, wdata_i, int_i, exc_valid_i, exc_code_i,
             exc_pc_i, exc_bd_i, exc_badvaddr_i, eret_i,
      input  data_o, status_o, cause_o, epc_o, int_pending_o, timer_int_o
   );

   modport slave (
      input  raddr_i, we_i, waddr_i, wdata_i, int_i, exc_valid_i, exc_code_i,
             exc_pc_i, exc_bd_i, exc_badvaddr_i, eret_i,
      output data_o, status_o, cause_o, epc_o, int_pending_o, timer_int_o
   );

endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer: free-running Count, Compare register and sticky match flag.
module cp0_timer
   import cp0_reg_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      count_we_i,
   input  logic      compare_we_i,
   input  data_bus_t wdata_i,
   output data_bus_t count_o,
   output data_bus_t compare_o,
   output logic      timer_int_o
);

   data_bus_t count_q, count_d;
   data_bus_t compare_q, compare_d;
   logic      timer_q, timer_d;

   always_comb begin
      count_d   = count_we_i ? wdata_i : count_q + 32'd1;
      compare_d = compare_we_i ? wdata_i : compare_q;
      timer_d   = timer_q;
      // Compare write wins over a simultaneous match
      if (compare_we_i)
         timer_d = 1'b0;
      else if (count_q == compare_q)
         timer_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q   <= '0;
         compare_q <= '0;
         timer_q   <= 1'b0;
      end else begin
         count_q   <= count_d;
         compare_q <= compare_d;
         timer_q   <= timer_d;
      end
   end

   assign count_o     = count_q;
   assign compare_o   = compare_q;
   assign timer_int_o = timer_q;

endmodule

// File: rtl/cp0_reg.sv
// MIPS32 CP0 register file: Status/Cause/EPC/BadVAddr/PRId, exception capture and interrupt flag.
// Define CP0_TIMER_EN to include the Count/Compare timer; otherwise Count/Compare read 0.
module cp0_reg
   import cp0_reg_pkg::*;
#(
   parameter data_bus_t PRID_VALUE   = 32'h0001_8000,
   parameter data_bus_t STATUS_RESET = 32'h1000_0000
)
(
   input  logic clk,
   input  logic rst,
   cp0_if.slave bus
);

   data_bus_t badvaddr_q, badvaddr_d;
   data_bus_t status_q, status_d;
   data_bus_t cause_q, cause_d;
   data_bus_t epc_q, epc_d;
   data_bus_t count, compare;
   logic      timer_int;
   logic      sw_we;
   data_bus_t rdata;

   // Exception and eret drop a same-cycle mtc0 entirely
   assign sw_we = bus.we_i & ~bus.exc_valid_i & ~bus.eret_i;

`ifdef CP0_TIMER_EN
   cp0_timer u_timer (
      .clk          (clk),
      .rst          (rst),
      .count_we_i   (sw_we && (bus.waddr_i == CP0_REG_COUNT)),
      .compare_we_i (sw_we && (bus.waddr_i == CP0_REG_COMPARE)),
      .wdata_i      (bus.wdata_i),
      .count_o      (count),
      .compare_o    (compare),
      .timer_int_o  (timer_int)
   );
`else
   assign count     = '0;
   assign compare   = '0;
   assign timer_int = 1'b0;
`endif

   always_comb begin
      badvaddr_d = badvaddr_q;
      status_d   = status_q;
      cause_d    = cause_q;
      epc_d      = epc_q;
      cause_d[15:10] = {timer_int | bus.int_i[5], bus.int_i[4:0]};
      if (bus.exc_valid_i) begin
         // Nested exception keeps the original EPC/BD
         if (!status_q[STATUS_EXL_BIT]) begin
            epc_d                  = bus.exc_bd_i ? bus.exc_pc_i - 32'd4 : bus.exc_pc_i;
            cause_d[CAUSE_BD_BIT]  = bus.exc_bd_i;
            status_d[STATUS_EXL_BIT] = 1'b1;
         end
         cause_d[6:2] = bus.exc_code_i;
         if ((bus.exc_code_i == EXC_ADEL) || (bus.exc_code_i == EXC_ADES))
            badvaddr_d = bus.exc_badvaddr_i;
      end else if (bus.eret_i) begin
         status_d[STATUS_EXL_BIT] = 1'b0;
      end else if (sw_we) begin
         case (bus.waddr_i)
            CP0_REG_STATUS: status_d = masked_write(status_q, bus.wdata_i, STATUS_WMASK);
            CP0_REG_CAUSE:  cause_d  = masked_write(cause_d, bus.wdata_i, CAUSE_WMASK);
            CP0_REG_EPC:    epc_d    = bus.wdata_i;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         badvaddr_q <= '0;
         status_q   <= STATUS_RESET;
         cause_q    <= '0;
         epc_q      <= '0;
      end else begin
         badvaddr_q <= badvaddr_d;
         status_q   <= status_d;
         cause_q    <= cause_d;
         epc_q      <= epc_d;
      end
   end

   always_comb begin
      rdata = '0;
      case (bus.raddr_i)
         CP0_REG_BADVADDR: rdata = badvaddr_q;
         CP0_REG_COUNT:    rdata = count;
         CP0_REG_COMPARE:  rdata = compare;
         CP0_REG_STATUS:   rdata = status_q;
         CP0_REG_CAUSE:    rdata = cause_q;
         CP0_REG_EPC:      rdata = epc_q;
         CP0_REG_PRID:     rdata = PRID_VALUE;
         default:          rdata = '0;
      endcase
   end

   assign bus.data_o        = rdata;
   assign bus.status_o      = status_q;
   assign bus.cause_o       = cause_q;
   assign bus.epc_o         = epc_q;
   assign bus.timer_int_o   = timer_int;
   assign bus.int_pending_o = status_q[STATUS_IE_BIT] & ~status_q[STATUS_EXL_BIT]
                              & (|(cause_q[15:8] & status_q[15:8]));

endmodule
